dft_tdi_serializer: RTL and testbench

//  Feeds the DFT probe TDI input: accepts parallel test-pattern words over a valid/ready

---
 rtl/dft_tdi_serializer.sv | 137 +++++++++++++
 tb/tb_dft_tdi_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dft_tdi_serializer.sv
// Parallel-to-serial feeder for the DFT probe TDI/TEN pins: MSB-first shifting,
// frames delimited by data_last, and a fixed ten-low gap between frames.
module dft_tdi_serializer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic        PAD_BIT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_last,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tdi_o,
    output logic             ten_o,
    output logic             busy,
    output logic             word_done,
    output logic             underrun
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, UNDERRUN, GAP} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] shreg;
    logic             last_flag;
    logic             xfer;
    logic             word_end;
    logic             tdi_next, ten_next, word_done_next, underrun_next;

    assign word_end = (state == SHIFT) && (bit_cnt == CNT_LAST);
    assign xfer     = data_valid && data_ready;

    // Ready only where a word can be taken without a bubble; abort masks it.
    always_comb begin
        data_ready = 1'b0;
        if (!abort) begin
            case (state)
                IDLE, UNDERRUN: data_ready = 1'b1;
                SHIFT:          data_ready = word_end && !last_flag;
                default:        data_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (xfer) state_next = SHIFT;
                SHIFT: begin
                    if (word_end) begin
                        if (last_flag)  state_next = GAP;
                        else if (xfer)  state_next = SHIFT;
                        else            state_next = UNDERRUN;
                    end
                end
                UNDERRUN: if (xfer) state_next = SHIFT;
                GAP:      if (gap_cnt == GAP_LAST) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, derived from the current state.
    always_comb begin
        tdi_next       = PAD_BIT;
        ten_next       = 1'b0;
        word_done_next = 1'b0;
        underrun_next  = underrun;
        if (abort) begin
            underrun_next = 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    tdi_next       = shreg[WIDTH-1];
                    ten_next       = 1'b1;
                    word_done_next = word_end;
                    if (word_end && !last_flag && !xfer) underrun_next = 1'b1;
                end
                UNDERRUN: ten_next = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            last_flag <= 1'b0;
            tdi_o     <= PAD_BIT;
            ten_o     <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            tdi_o     <= tdi_next;
            ten_o     <= ten_next;
            busy      <= (state_next != IDLE);
            word_done <= word_done_next;
            underrun  <= underrun_next;

            if (xfer) begin
                shreg     <= data_in;
                last_flag <= data_last;
                bit_cnt   <= '0;
            end else if (state == SHIFT) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
                if (!word_end) bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == GAP) begin
                if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dft_tdi_serializer.sv
// Randomized bench for dft_tdi_serializer: a cycle-stamped reference model fills an
// expected-bit queue on every accepted word; a negedge monitor checks all outputs.
module tb_dft_tdi_serializer;
    localparam int unsigned W   = 16;
    localparam int unsigned G   = 4;
    localparam logic        PAD = 1'b0;

    logic         clk, rst, abort;
    logic [W-1:0] data_in;
    logic         data_last, data_valid;
    logic         data_ready, tdi_o, ten_o, busy, word_done, underrun;

    dft_tdi_serializer #(.WIDTH(W), .GAP_CYCLES(G), .PAD_BIT(PAD)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .data_in(data_in), .data_last(data_last), .data_valid(data_valid),
        .data_ready(data_ready), .tdi_o(tdi_o), .ten_o(ten_o),
        .busy(busy), .word_done(word_done), .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {int stamp; logic tdi; logic wd;} exp_t;
    exp_t q[$];

    int n_vec = 0, n_miss = 0;
    int cyc = 0, acc_cnt = 0;
    int w_start = 0, idle_edge = 0;
    bit in_frame = 0, exp_under = 0, pad_now = 0;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @cycle %0d: got %b, want %b", nm, cyc, act, exp);
        end
    endtask

    // Would a word be accepted at edge number e?
    function automatic bit model_ready(input int e);
        if (abort) return 1'b0;
        if (in_frame) return e >= w_start + int'(W);
        return e >= idle_edge;
    endfunction

    // Reference model: each accepted word occupies output cycles a+1..a+W; starved frames pad.
    initial begin
        logic [W-1:0] w;
        bit xfer;
        forever begin
            @(posedge clk);
            cyc++;
            xfer = !rst && data_valid && model_ready(cyc);
            if (rst || abort) begin
                q.delete();
                in_frame  = 0;
                idle_edge = cyc + 1;
                exp_under = 0;
                pad_now   = 0;
            end else begin
                pad_now = in_frame && (cyc > w_start + int'(W));
                if (in_frame && cyc == w_start + int'(W) && !xfer) exp_under = 1;
                if (xfer) begin
                    w = data_in;
                    for (int i = 0; i < int'(W); i++)
                        q.push_back('{cyc + 1 + i, w[int'(W) - 1 - i], i == int'(W) - 1});
                    w_start  = cyc;
                    in_frame = !data_last;
                    if (data_last) idle_edge = cyc + int'(W) + int'(G) + 1;
                    acc_cnt++;
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic et, ed, ew;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                if (q.size() > 0 && q[0].stamp <= cyc) begin
                    e  = q.pop_front();
                    et = 1'b1; ed = e.tdi; ew = e.wd;
                    if (e.stamp != cyc) begin
                        et = 1'bx;
                        chk("stamp", 1'b0, 1'b1);
                    end
                end else begin
                    et = pad_now; ed = PAD; ew = 1'b0;
                end
                chk("ten_o", ten_o, et);
                chk("tdi_o", tdi_o, ed);
                chk("word_done", word_done, ew);
                chk("underrun", underrun, exp_under);
                chk("busy", busy, in_frame || (cyc < idle_edge - 1));
                if (!rst) chk("data_ready", data_ready, model_ready(cyc + 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the word valid until accepted; with churn, data_in changes while waiting.
    task automatic send(input logic [W-1:0] d, input bit last, input bit churn);
        int n0;
        bit got;
        n0 = acc_cnt;
        got = 0;
        data_in = d; data_last = last; data_valid = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            tick();
            if (acc_cnt != n0) got = 1;
            else if (churn) data_in = W'($urandom);
        end
        if (!got) begin
            n_miss++;
            $display("FAIL accept_timeout @cycle %0d: got no transfer, want one", cyc);
        end
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        data_in    = W'($urandom);
        data_last  = 1'($urandom);
        repeat (n) tick();
    endtask

    task automatic do_abort();
        abort      = 1'b1;
        data_valid = 1'($urandom);
        data_in    = W'($urandom);
        tick();
        abort      = 1'b0;
        data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0;
        data_valid = 1'b1; data_in = 16'hAAAA; data_last = 1'b1;
        repeat (3) tick();
        rst = 1'b0; data_valid = 1'b0;
        tick();

        send(16'hA5C3, 1, 0); idle(W + G + 2);

        send(16'hFFFF, 0, 0); send(16'h0000, 0, 0); send(16'h8001, 1, 0);
        idle(W + G + 2);

        send(16'h5A0F, 0, 0); idle(W + 4); send(16'hC3C3, 1, 0);
        idle(W + G + 2);
        send(16'h0F0F, 1, 0); idle(W + G + 2);
        do_abort(); idle(2);

        send(16'h1234, 1, 0); idle(7); do_abort();
        send(16'hBEEF, 1, 0); idle(W + G + 2);

        send(16'h7E81, 1, 0); send(16'h3C5A, 1, 1); idle(W + G + 2);

        for (int f = 0; f < 40; f++) begin
            int k;
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                if ($urandom % 4 == 0) idle($urandom_range(1, W + 3));
                send(W'($urandom), i == k - 1, 1'($urandom));
                if ($urandom % 10 == 0) begin
                    idle($urandom_range(0, W + 2));
                    do_abort();
                    break;
                end
            end
            idle($urandom_range(0, 3));
        end

        idle(W + G + 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
